wb_uart_rx_fifo: RTL

WB_UART_RX_FIFO -- requirements
Module: wb_uart_rx_fifo

---
 rtl/wb_uart_pkg.sv | 38 +++
 rtl/wb_uart_fifo.sv | 47 ++++
 rtl/wb_uart_rx_fifo.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/wb_uart_pkg.sv
// Shared definitions for the Wishbone UART receiver: FSM encoding, register map,
// status layout and parity modes.
package wb_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_e;

    localparam logic ADR_DATA   = 1'b0;
    localparam logic ADR_STATUS = 1'b1;

    localparam int unsigned STAT_NE  = 0;
    localparam int unsigned STAT_PE  = 1;
    localparam int unsigned STAT_FE  = 2;
    localparam int unsigned STAT_OVR = 3;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef struct packed {
        logic [3:0] rsvd;
        logic       ovr;
        logic       fe;
        logic       pe;
        logic       ne;
    } status_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/wb_uart_fifo.sv
// Small synchronous FIFO; a pop frees the head slot in the same cycle, so a
// simultaneous push into a full FIFO is accepted.
module wb_uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Storage needs no reset: pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/wb_uart_rx_fifo.sv
// UART receiver with majority-vote sampling, parity/framing/break handling and a
// receive FIFO behind a two-register Wishbone slave (DATA, STATUS).
module wb_uart_rx_fifo
    import wb_uart_pkg::*;
#(
    parameter int unsigned TICKS_PER_BAUD = 16,
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned PARITY         = 0,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_ni,
    input  logic       wb_cyc_i,
    input  logic       wb_stb_i,
    input  logic       wb_we_i,
    input  logic       wb_adr_i,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    output logic       wb_ack_o,
    input  logic       uart_rx,
    output logic       irq_o
);

    localparam int unsigned TW = 8;
    localparam int unsigned BW = 4;
    localparam logic [TW-1:0] TICK_LO   = TW'(TICKS_PER_BAUD / 2 - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(TICKS_PER_BAUD / 2);
    localparam logic [TW-1:0] TICK_HI   = TW'(TICKS_PER_BAUD / 2 + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BAUD - 1);

    rx_state_e            state_q, state_d;
    logic                 rx_meta_q, rx_sync_q;
    logic [TW-1:0]        tick_q;
    logic [BW-1:0]        bit_cnt_q;
    logic [DATA_BITS-1:0] sr_q;
    logic                 s0_q, s1_q;
    logic                 par_err_q;
    logic                 pe_q, fe_q, ovr_q;

    logic vote_c, at_hi_c, at_last_c;
    logic push_c, pe_set_c, fe_set_c, shift_c, par_cap_c;
    logic req_c, rd_c, wr_c, pop_c, clr_c, ovr_set_c;
    logic fifo_full, fifo_empty;
    logic [7:0] fifo_head;
    status_t    status_c;
    logic [7:0] rd_data_c;
    logic       unused_dat;

    assign unused_dat = ^{wb_dat_i[7:4], wb_dat_i[0]};

    // Two-flop synchronizer, idle-high after reset.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    assign vote_c    = maj3(s0_q, s1_q, rx_sync_q);
    assign at_hi_c   = (tick_q == TICK_HI);
    assign at_last_c = (tick_q == TICK_LAST);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!rx_sync_q) state_d = ST_START;
            ST_START: begin
                if (at_hi_c && vote_c) state_d = ST_IDLE;
                else if (at_last_c)    state_d = ST_DATA;
            end
            ST_DATA: begin
                if (at_last_c && bit_cnt_q == BW'(DATA_BITS - 1))
                    state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: if (at_last_c) state_d = ST_STOP;
            ST_STOP:   if (at_hi_c) state_d = vote_c ? ST_IDLE : ST_BREAK;
            ST_BREAK:  if (rx_sync_q) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Stop is judged at its majority point; no need to wait out the bit.
    always_comb begin
        push_c    = 1'b0;
        pe_set_c  = 1'b0;
        fe_set_c  = 1'b0;
        shift_c   = 1'b0;
        par_cap_c = 1'b0;
        case (state_q)
            ST_DATA:   shift_c   = at_hi_c;
            ST_PARITY: par_cap_c = at_hi_c;
            ST_STOP: begin
                if (at_hi_c) begin
                    if (!vote_c)        fe_set_c = 1'b1;
                    else if (par_err_q) pe_set_c = 1'b1;
                    else                push_c   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            tick_q    <= '0;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            s0_q      <= 1'b1;
            s1_q      <= 1'b1;
            par_err_q <= 1'b0;
        end else begin
            if (state_d != state_q || at_last_c || state_q == ST_IDLE || state_q == ST_BREAK)
                tick_q <= '0;
            else
                tick_q <= tick_q + TW'(1);
            if (tick_q == TICK_LO)  s0_q <= rx_sync_q;
            if (tick_q == TICK_MID) s1_q <= rx_sync_q;
            if (state_q != ST_DATA) bit_cnt_q <= '0;
            else if (at_last_c)     bit_cnt_q <= bit_cnt_q + BW'(1);
            if (shift_c) sr_q <= {vote_c, sr_q[DATA_BITS-1:1]};
            if (state_q == ST_IDLE) par_err_q <= 1'b0;
            else if (par_cap_c)     par_err_q <= ((^sr_q) ^ vote_c) != (PARITY == PAR_ODD);
        end
    end

    wb_uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .push  (push_c),
        .pop   (pop_c),
        .wdata (8'(sr_q)),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign req_c     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign rd_c      = req_c & ~wb_we_i;
    assign wr_c      = req_c & wb_we_i;
    assign pop_c     = rd_c & (wb_adr_i == ADR_DATA) & ~fifo_empty;
    assign clr_c     = wr_c & (wb_adr_i == ADR_STATUS);
    assign ovr_set_c = push_c & fifo_full & ~pop_c;

    always_comb begin
        status_c     = '0;
        status_c.ovr = ovr_q;
        status_c.fe  = fe_q;
        status_c.pe  = pe_q;
        status_c.ne  = ~fifo_empty;
        rd_data_c    = status_c;
        if (wb_adr_i == ADR_DATA) rd_data_c = fifo_empty ? 8'h00 : fifo_head;
    end

    // A flag being set wins over a simultaneous write-1-clear.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            pe_q     <= 1'b0;
            fe_q     <= 1'b0;
            ovr_q    <= 1'b0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            irq_o    <= 1'b0;
        end else begin
            pe_q     <= pe_set_c  | (pe_q  & ~(clr_c & wb_dat_i[STAT_PE]));
            fe_q     <= fe_set_c  | (fe_q  & ~(clr_c & wb_dat_i[STAT_FE]));
            ovr_q    <= ovr_set_c | (ovr_q & ~(clr_c & wb_dat_i[STAT_OVR]));
            wb_ack_o <= req_c;
            wb_dat_o <= rd_c ? rd_data_c : 8'h00;
            irq_o    <= ~fifo_empty | pe_q | fe_q | ovr_q;
        end
    end

endmodule
